// File: rtl/td4_pkg.sv
// Shared TD4 definitions: loader FSM states and the CPU bus widths.
package td4_pkg;

    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_LOAD,
        ST_CHECK,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } td4_ldr_state_t;

endpackage

// File: rtl/td4_prog_ram.sv
// TD4 program memory: one synchronous write port, one asynchronous read port.
// Deliberately has no reset so a reset mid-load keeps the bytes already written.
module td4_prog_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 fetch-side responder: loads 16 program bytes plus a checksum from a
// valid/ready stream and holds the CPU in reset until a verified load completes.
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = TD4_ADDR_W,
    parameter int DATA_W        = TD4_DATA_W,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              cpu_n_reset,
    output logic              load_ok,
    output logic              load_err
);

    localparam int CNT_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    td4_ldr_state_t    state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              n_reset_d;
    logic              ok_d;
    logic              mem_we;
    logic              xfer;

    td4_prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q),
        .wdata (load_data),
        .raddr (address),
        .rdata (instr)
    );

    assign load_ready = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !load_start;
    assign xfer       = load_valid && load_ready;
    assign load_err   = (state_q == ST_ERROR);

    // load_start overrides everything; the CPU reset output is derived from the next state
    // so it is registered and only ever high while in RUN.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;

        if (load_start) begin
            state_d = ST_LOAD;
            wptr_d  = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (xfer) begin
                        mem_we = 1'b1;
                        sum_d  = sum_q + load_data;
                        wptr_d = wptr_q + 1'b1;
                        if (wptr_q == ADDR_W'(DEPTH - 1)) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        if (load_data == sum_q) begin
                            state_d = ST_RELEASE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_RELEASE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(RELEASE_DELAY - 1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end

        n_reset_d = (state_d == ST_RUN);
        ok_d      = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            wptr_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            cpu_n_reset <= 1'b0;
            load_ok     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            cpu_n_reset <= n_reset_d;
            load_ok     <= ok_d;
        end
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: drives on the falling edge (+1), checks with
// immediate assertions against hand-computed values.
module tb_td4_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] address;
    logic [7:0] instr;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       cpu_n_reset;
    logic       load_ok;
    logic       load_err;

    int tests_run  = 0;
    int fail_count = 0;

    td4_prog_loader dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .instr       (instr),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .cpu_n_reset (cpu_n_reset),
        .load_ok     (load_ok),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold the given inputs for one clock, then return to idle.
    task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data);
        load_start = start;
        load_valid = valid;
        load_data  = data;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int waited;
        waited     = 0;
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        #1;
        while (!load_ready && waited < 64) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("load_ready_before_xfer", load_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        #1;
    endtask

    task automatic check_mem(input string tag, input int base, input int step);
        for (int k = 0; k < 16; k++) begin
            address = 4'(k);
            #1;
            checkOutput(tag, instr, 32'((base + k * step) & 8'hFF));
        end
    endtask

    initial begin
        int waited;
        reset      = 1'b1;
        address    = 4'h0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;

        // Test 1: reset state
        for (int k = 0; k < 16; k++) begin
            address = 4'(k);
            #1;
        end
        checkOutput("rst_cpu_n_reset", cpu_n_reset, 1'b0);
        checkOutput("rst_load_ready", load_ready, 1'b0);
        checkOutput("rst_load_ok", load_ok, 1'b0);
        checkOutput("rst_load_err", load_err, 1'b0);

        // Test 2: bytes 0..15, checksum 0x78, release timing
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t2_ready_in_load", load_ready, 1'b1);
        for (int k = 0; k < 16; k++) send_byte(8'(k));
        checkOutput("t2_ready_in_check", load_ready, 1'b1);
        send_byte(8'h78);
        checkOutput("t2_nrst_c0", cpu_n_reset, 1'b0);
        checkOutput("t2_ok_c0", load_ok, 1'b0);
        idle(1);
        checkOutput("t2_nrst_c1", cpu_n_reset, 1'b0);
        checkOutput("t2_ok_c1", load_ok, 1'b0);
        idle(1);
        checkOutput("t2_nrst_c2", cpu_n_reset, 1'b1);
        checkOutput("t2_ok_c2", load_ok, 1'b1);
        idle(1);
        checkOutput("t2_nrst_c3", cpu_n_reset, 1'b1);
        checkOutput("t2_ok_c3", load_ok, 1'b0);
        checkOutput("t2_ready_in_run", load_ready, 1'b0);
        check_mem("t2_instr", 0, 1);

        // Test 3: bad checksum 0x77
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t3_nrst_after_start", cpu_n_reset, 1'b0);
        for (int k = 0; k < 16; k++) send_byte(8'(k));
        send_byte(8'h77);
        checkOutput("t3_err", load_err, 1'b1);
        checkOutput("t3_nrst", cpu_n_reset, 1'b0);
        idle(3);
        checkOutput("t3_err_held", load_err, 1'b1);
        checkOutput("t3_nrst_held", cpu_n_reset, 1'b0);
        checkOutput("t3_ready_in_err", load_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t3_err_cleared", load_err, 1'b0);
        checkOutput("t3_ready_after_start", load_ready, 1'b1);

        // Test 4: 0xFF x16, checksum 0xF0 (wrapping sum)
        for (int k = 0; k < 16; k++) send_byte(8'hFF);
        send_byte(8'hF0);
        checkOutput("t4_err", load_err, 1'b0);
        idle(2);
        checkOutput("t4_nrst", cpu_n_reset, 1'b1);
        address = 4'h9;
        #1;
        checkOutput("t4_instr9", instr, 8'hFF);

        // Test 5: gaps, restart with a byte offered alongside load_start
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t5_nrst_after_start", cpu_n_reset, 1'b0);
        for (int k = 0; k < 7; k++) begin
            idle($urandom_range(0, 2));
            send_byte(8'hA0 + 8'(k));
        end
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        #1;
        checkOutput("t5_ready_during_start", load_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        #1;
        checkOutput("t5_ready_after_restart", load_ready, 1'b1);
        for (int k = 0; k < 16; k++) begin
            idle($urandom_range(0, 2));
            send_byte(8'(k * 17));
        end
        idle($urandom_range(0, 2));
        send_byte(8'hF8);
        waited = 0;
        while (!cpu_n_reset && waited < 10) begin
            idle(1);
            waited++;
        end
        checkOutput("t5_nrst", cpu_n_reset, 1'b1);
        checkOutput("t5_err", load_err, 1'b0);
        check_mem("t5_instr", 0, 17);

        // Test 6: reset while in CHECK keeps memory
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 16; k++) send_byte(8'h50 + 8'(k));
        checkOutput("t6_ready_in_check", load_ready, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("t6_ready_in_reset", load_ready, 1'b0);
        checkOutput("t6_nrst_in_reset", cpu_n_reset, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t6_ready_hold", load_ready, 1'b0);
        checkOutput("t6_nrst_hold", cpu_n_reset, 1'b0);
        checkOutput("t6_err_hold", load_err, 1'b0);
        idle(1);
        checkOutput("t6_nrst_hold2", cpu_n_reset, 1'b0);
        check_mem("t6_instr", 8'h50, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
